// File: rtl/req_arbiter_4.sv
// Four-way request arbiter: fixed priority (req[3] highest) with grant locking,
// a max-hold timeout that forces a one-cycle gap, and a starvation boost.
module req_arbiter_4 #(
    parameter int unsigned MAX_HOLD     = 8,
    parameter int unsigned STARVE_LIMIT = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       busy,
    output logic       hold_expired
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    localparam logic [7:0] HOLD_LAST  = 8'(MAX_HOLD - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state;
    logic [7:0] hold_cnt;
    logic [3:0] wait_cnt [4];
    logic [3:0] starved;
    logic [3:0] cand;
    logic [1:0] win_id;

    // Starved requesters form their own priority tier above plain requests.
    always_comb begin
        starved = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            starved[i] = req[i] && (wait_cnt[i] == STARVE_MAX);
        end
        cand   = (starved != '0) ? starved : req;
        win_id = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (cand[i]) begin
                win_id = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            gnt          <= '0;
            gnt_id       <= '0;
            gnt_valid    <= 1'b0;
            busy         <= 1'b0;
            hold_expired <= 1'b0;
            hold_cnt     <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (!req[i] || gnt[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != STARVE_MAX) begin
                    wait_cnt[i] <= wait_cnt[i] + 4'd1;
                end
            end

            hold_expired <= 1'b0;

            case (state)
                IDLE, GAP: begin
                    if (req != '0) begin
                        state     <= GRANT;
                        gnt       <= 4'b0001 << win_id;
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
                        busy      <= 1'b1;
                        hold_cnt  <= '0;
                    end else begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!req[gnt_id] || (hold_cnt == HOLD_LAST)) begin
                        state        <= GAP;
                        gnt          <= '0;
                        gnt_id       <= '0;
                        gnt_valid    <= 1'b0;
                        busy         <= 1'b1;
                        // A voluntary drop takes precedence over a coincident timeout.
                        hold_expired <= req[gnt_id];
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_id    <= '0;
                    gnt_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_arbiter_4.sv
// Directed and random checks for req_arbiter_4 using a scoreboard of expected
// per-cycle outputs and immediate assertions.
module tb_req_arbiter_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] id_a, id_b;
    logic       val_a, val_b, busy_a, busy_b, he_a, he_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic       dut;
        logic [3:0] gnt;
        logic       he;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    req_arbiter_4 #(.MAX_HOLD(8), .STARVE_LIMIT(6)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .gnt_id(id_a),
        .gnt_valid(val_a), .busy(busy_a), .hold_expired(he_a)
    );

    req_arbiter_4 #(.MAX_HOLD(4), .STARVE_LIMIT(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .gnt_id(id_b),
        .gnt_valid(val_b), .busy(busy_b), .hold_expired(he_b)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] enc(input logic [3:0] g);
        enc = '0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) enc = 2'(i);
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare(input exp_t e);
        logic [3:0] g;
        logic [1:0] id;
        logic       v, b, h;
        if (e.dut) begin
            g = gnt_b; id = id_b; v = val_b; b = busy_b; h = he_b;
        end else begin
            g = gnt_a; id = id_a; v = val_a; b = busy_a; h = he_a;
        end
        check({e.tag, " gnt"},          32'(g),  32'(e.gnt));
        check({e.tag, " gnt_id"},       32'(id), 32'(enc(e.gnt)));
        check({e.tag, " gnt_valid"},    32'(v),  32'(|e.gnt));
        check({e.tag, " busy"},         32'(b),  32'(e.busy));
        check({e.tag, " hold_expired"}, 32'(h),  32'(e.he));
    endtask

    // Check outputs immediately, without a clock edge.
    task automatic now(input string tag, input logic sel, input logic [3:0] eg,
                       input logic eh, input logic eb);
        exp_t e;
        e.tag = tag; e.dut = sel; e.gnt = eg; e.he = eh; e.busy = eb;
        sb.push_back(e);
        compare(sb.pop_front());
    endtask

    // Drive req for the current cycle, expect the given outputs in the next one.
    task automatic cyc(input string tag, input logic sel, input logic [3:0] r,
                       input logic [3:0] eg, input logic eh, input logic eb);
        exp_t e;
        if (sel) begin
            req_b = r; req_a = '0;
        end else begin
            req_a = r; req_b = '0;
        end
        e.tag = tag; e.dut = sel; e.gnt = eg; e.he = eh; e.busy = eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(sb.pop_front());
    endtask

    initial begin
        logic [3:0] prev_g;
        logic [3:0] nr;
        int         cool [4];
        int         waitc [4];
        int         run;

        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        #12;
        now("reset a", 1'b0, 4'b0000, 1'b0, 1'b0);
        now("reset b", 1'b1, 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("idle", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // T1: asynchronous reset in the middle of a grant
        cyc("t1 grant", 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        now("t1 async reset", 1'b0, 4'b0000, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        now("t1 no grant before edge", 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc("t1 regrant", 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b1);
        cyc("t1 gap",     1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        cyc("t1 idle",    1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // T2: priority and normal release
        cyc("t2 c1", 1'b0, 4'b0110, 4'b0100, 1'b0, 1'b1);
        cyc("t2 c2", 1'b0, 4'b0110, 4'b0100, 1'b0, 1'b1);
        cyc("t2 c3", 1'b0, 4'b0110, 4'b0100, 1'b0, 1'b1);
        cyc("t2 c4", 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1);
        cyc("t2 c5", 1'b0, 4'b0010, 4'b0010, 1'b0, 1'b1);
        cyc("t2 c6", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        cyc("t2 c7", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // T3: MAX_HOLD=8 timeout
        for (int k = 0; k < 8; k++) begin
            cyc("t3 hold", 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b1);
        end
        cyc("t3 gap",     1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1);
        cyc("t3 regrant", 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b1);
        cyc("t3 drop",    1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        cyc("t3 idle",    1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // T4: starvation boost with MAX_HOLD=4
        for (int k = 0; k < 4; k++) begin
            cyc("t4 first hold", 1'b1, 4'b1001, 4'b1000, 1'b0, 1'b1);
        end
        cyc("t4 gap5", 1'b1, 4'b1001, 4'b0000, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc("t4 second hold", 1'b1, 4'b1001, 4'b1000, 1'b0, 1'b1);
        end
        cyc("t4 gap10",   1'b1, 4'b1001, 4'b0000, 1'b1, 1'b1);
        cyc("t4 boost11", 1'b1, 4'b1001, 4'b0001, 1'b0, 1'b1);
        cyc("t4 gap12",   1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1);
        cyc("t4 idle13",  1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // T5: drop on the last hold cycle is a normal release
        for (int k = 0; k < 4; k++) begin
            cyc("t5 hold", 1'b1, 4'b0010, 4'b0010, 1'b0, 1'b1);
        end
        cyc("t5 gap",  1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1);
        cyc("t5 idle", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // T6: random traffic on the MAX_HOLD=8 instance; a requester drops
        // only once served and then stays quiet for 16 cycles.
        prev_g = '0;
        run    = 0;
        for (int i = 0; i < 4; i++) begin
            cool[i]  = 0;
            waitc[i] = 0;
        end
        for (int n = 0; n < 10000; n++) begin
            check("t6 onehot",    32'($onehot0(gnt_a)), 32'd1);
            check("t6 gnt_id",    32'(id_a), 32'(enc(gnt_a)));
            check("t6 gnt_valid", 32'(val_a), 32'(|gnt_a));
            run = (gnt_a != '0) ? run + 1 : 0;
            check("t6 hold len",  32'(run <= 8), 32'd1);

            nr = req_a;
            for (int i = 0; i < 4; i++) begin
                if (gnt_a[i]) begin
                    nr[i] = ($urandom_range(0, 2) != 0);
                    if (!nr[i]) cool[i] = 16;
                end else if (prev_g[i]) begin
                    nr[i]   = 1'b0;
                    cool[i] = 16;
                end else if (req_a[i]) begin
                    nr[i] = 1'b1;
                end else if (cool[i] > 0) begin
                    cool[i]--;
                    nr[i] = 1'b0;
                end else begin
                    nr[i] = ($urandom_range(0, 3) == 0);
                end
                waitc[i] = (nr[i] && !gnt_a[i]) ? waitc[i] + 1 : 0;
            end
            check("t6 wait bound", 32'((waitc[0] <= 33) && (waitc[1] <= 33) &&
                                       (waitc[2] <= 33) && (waitc[3] <= 33)), 32'd1);
            prev_g = gnt_a;
            req_a  = nr;
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
